i2c_slave: RTL and testbench

- I2C target (slave) that answers the team's I2C master on the same two-wire bus.
- Oversamples scl/sda with the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address and ACKs it; receives write bytes or returns read bytes, with multi-byte bursts in both directions.
- Open-drain on sda: it only ever pulls low, never drives high.

---
 rtl/i2c_slave.sv | 198 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target: oversampled scl/sda, START/STOP detection, fixed 7-bit address,
// burst writes and burst reads with open-drain sda.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy,
    output logic       addr_hit
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [6:0]             shreg;
    logic [2:0]             bit_cnt;
    logic                   byte_done;
    logic                   rw;
    logic                   sda_oe;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Synchronisers reset to the idle-bus level so no false edge follows reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            addr_hit  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start_det) begin
                busy      <= 1'b1;
                addr_hit  <= 1'b0;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
                state     <= ADDR;
            end else if (stop_det) begin
                busy      <= 1'b0;
                addr_hit  <= 1'b0;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && !byte_done) begin
                            shreg   <= {shreg[5:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            // 8th bit is r_w; shreg already holds the address
                            if (bit_cnt == 3'd7) begin
                                rw <= sda_s;
                                if (shreg == SLAVE_ADDR) begin
                                    addr_hit  <= 1'b1;
                                    byte_done <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            state     <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                tx_req <= 1'b1;
                                shreg  <= tx_data[6:0];
                                sda_oe <= ~tx_data[7];
                                state  <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise && !byte_done) begin
                            shreg   <= {shreg[5:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {shreg, sda_s};
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            state     <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        // bit7 was placed at load; each fall presents the next bit
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RD_ACK;
                            end else begin
                                sda_oe  <= ~shreg[6];
                                shreg   <= {shreg[5:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state <= WAIT_STOP;
                            end else begin
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            tx_req    <= 1'b1;
                            shreg     <= tx_data[6:0];
                            sda_oe    <= ~tx_data[7];
                            bit_cnt   <= '0;
                            state     <= RD_DATA;
                        end
                    end
                    IDLE, WAIT_STOP: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level I2C master tasks plus a transaction-level
// expectation model (address match -> ACKs, write log, read byte source).
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam time Q = 50;
    localparam logic [6:0] ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_low;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       addr_hit;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    int errors = 0;
    int checks = 0;

    int         rx_cnt = 0;
    int         txreq_cnt = 0;
    int         slave_low_cnt = 0;
    int         busy_fall_cnt = 0;
    logic       busy_q = 1'b0;
    logic [7:0] rx_log [256];

    i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .busy     (busy),
        .addr_hit (addr_hit)
    );

    always #5 clk = ~clk;

    // Event monitor: logs received bytes and counts pulses / slave pull-downs
    always @(posedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_log[rx_cnt[7:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_req === 1'b1) txreq_cnt <= txreq_cnt + 1;
        if (sda === 1'b0 && !m_low) slave_low_cnt <= slave_low_cnt + 1;
        if (busy_q && !busy) busy_fall_cnt <= busy_fall_cnt + 1;
        busy_q <= busy;
    end

    task automatic mstart();
        m_low = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        m_low = 1'b1; #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic mstop();
        m_low = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        m_low = 1'b0; #(Q);
    endtask

    task automatic wbit(input bit b);
        m_low = !b; #(Q);
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #(Q);
    endtask

    task automatic rbit(output bit b);
        m_low = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        b = (sda !== 1'b0);
        #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output bit acked);
        bit b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        acked = !b;
    endtask

    task automatic rbyte(input bit ack, output logic [7:0] d);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(!ack);
    endtask

    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
        #(100);
        rst = 1'b0;
        #(100);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b exp 0", rx_valid); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b exp 0", tx_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (addr_hit !== 1'b0) begin errors++; $display("FAIL reset_addr_hit: got %b exp 0", addr_hit); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b exp 1", sda); end
    endtask

    task automatic test_write_single();
        bit ack;
        int rx0 = rx_cnt;
        mstart();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr1_busy_start: got %b exp 1", busy); end
        wbyte({ADDR, 1'b0}, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr1_addr_ack: got %b exp 1", ack); end
        checks++; if (addr_hit !== 1'b1) begin errors++; $display("FAIL wr1_addr_hit: got %b exp 1", addr_hit); end
        wbyte(8'hA5, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr1_data_ack: got %b exp 1", ack); end
        checks++; if (rx_cnt - rx0 !== 1) begin errors++; $display("FAIL wr1_rx_pulses: got %0d exp 1", rx_cnt - rx0); end
        checks++; if (rx_log[8'(rx0)] !== 8'hA5) begin errors++; $display("FAIL wr1_rx_log: got %h exp a5", rx_log[8'(rx0)]); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL wr1_rx_data: got %h exp a5", rx_data); end
        mstop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr1_busy_stop: got %b exp 0", busy); end
        checks++; if (addr_hit !== 1'b0) begin errors++; $display("FAIL wr1_hit_stop: got %b exp 0", addr_hit); end
    endtask

    task automatic test_addr_mismatch();
        bit ack;
        int rx0 = rx_cnt;
        int lo0 = slave_low_cnt;
        mstart();
        wbyte({7'h51, 1'b0}, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mis_addr_ack: got %b exp 0", ack); end
        checks++; if (addr_hit !== 1'b0) begin errors++; $display("FAIL mis_addr_hit: got %b exp 0", addr_hit); end
        wbyte(8'h3C, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mis_data_ack: got %b exp 0", ack); end
        mstop();
        checks++; if (slave_low_cnt !== lo0) begin errors++; $display("FAIL mis_sda_driven: got %0d exp %0d", slave_low_cnt, lo0); end
        checks++; if (rx_cnt !== rx0) begin errors++; $display("FAIL mis_rx_valid: got %0d exp %0d", rx_cnt, rx0); end
    endtask

    task automatic test_read_two();
        bit ack;
        logic [7:0] d;
        int t0 = txreq_cnt;
        tx_data = 8'hC3;
        mstart();
        wbyte({ADDR, 1'b1}, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd2_addr_ack: got %b exp 1", ack); end
        tx_data = 8'h5A;
        rbyte(1'b1, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rd2_byte1: got %h exp c3", d); end
        rbyte(1'b0, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rd2_byte2: got %h exp 5a", d); end
        checks++; if (txreq_cnt - t0 !== 2) begin errors++; $display("FAIL rd2_tx_req: got %0d exp 2", txreq_cnt - t0); end
        m_low = 1'b0; #(Q);
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rd2_released: got %b exp 1", sda); end
        mstop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd2_busy_stop: got %b exp 0", busy); end
    endtask

    task automatic test_repeated_start();
        bit ack;
        logic [7:0] d;
        int bf0;
        mstart();
        wbyte({ADDR, 1'b0}, ack);
        wbyte(8'h11, ack);
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL rs_rx_data: got %h exp 11", rx_data); end
        bf0 = busy_fall_cnt;
        tx_data = 8'h77;
        mstart();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy: got %b exp 1", busy); end
        wbyte({ADDR, 1'b1}, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rs_addr_ack: got %b exp 1", ack); end
        rbyte(1'b0, d);
        checks++; if (d !== 8'h77) begin errors++; $display("FAIL rs_read: got %h exp 77", d); end
        checks++; if (busy_fall_cnt !== bf0) begin errors++; $display("FAIL rs_busy_drop: got %0d exp %0d", busy_fall_cnt, bf0); end
        mstop();
    endtask

    task automatic test_write_burst(input int n, input bit rnd);
        bit ack;
        logic [7:0] d;
        logic [7:0] exp_q [$];
        int rx0 = rx_cnt;
        mstart();
        wbyte({ADDR, 1'b0}, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL burst_addr_ack: got %b exp 1", ack); end
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : 8'(i + 1);
            exp_q.push_back(d);
            wbyte(d, ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL burst_data_ack%0d: got %b exp 1", i, ack); end
        end
        mstop();
        checks++; if (rx_cnt - rx0 !== n) begin errors++; $display("FAIL burst_count: got %0d exp %0d", rx_cnt - rx0, n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (rx_log[8'(rx0 + i)] !== exp_q[i]) begin errors++; $display("FAIL burst_byte%0d: got %h exp %h", i, rx_log[8'(rx0 + i)], exp_q[i]); end
        end
    endtask

    task automatic test_random(input int iters);
        bit ack;
        bit rw;
        bit hit;
        int n;
        int rx0;
        int t0;
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] src [4];
        for (int it = 0; it < iters; it++) begin
            a   = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom);
            rw  = 1'($urandom);
            n   = int'($urandom_range(1, 4));
            hit = (a == ADDR);
            rx0 = rx_cnt;
            t0  = txreq_cnt;
            for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
            tx_data = src[0];
            mstart();
            wbyte({a, rw}, ack);
            checks++; if (ack !== hit) begin errors++; $display("FAIL rnd%0d_addr_ack: got %b exp %b", it, ack, hit); end
            if (!rw) begin
                for (int i = 0; i < n; i++) begin
                    wbyte(src[i], ack);
                    checks++; if (ack !== hit) begin errors++; $display("FAIL rnd%0d_wr_ack%0d: got %b exp %b", it, i, ack, hit); end
                end
                checks++; if (rx_cnt - rx0 !== (hit ? n : 0)) begin errors++; $display("FAIL rnd%0d_rx_count: got %0d exp %0d", it, rx_cnt - rx0, hit ? n : 0); end
                if (hit) begin
                    for (int i = 0; i < n; i++) begin
                        checks++; if (rx_log[8'(rx0 + i)] !== src[i]) begin errors++; $display("FAIL rnd%0d_rx%0d: got %h exp %h", it, i, rx_log[8'(rx0 + i)], src[i]); end
                    end
                end
            end else begin
                for (int i = 0; i < n; i++) begin
                    if (i + 1 < 4) tx_data = src[i + 1];
                    rbyte(i < n - 1, d);
                    checks++; if (d !== (hit ? src[i] : 8'hFF)) begin errors++; $display("FAIL rnd%0d_rd%0d: got %h exp %h", it, i, d, hit ? src[i] : 8'hFF); end
                end
                checks++; if (txreq_cnt - t0 !== (hit ? n : 0)) begin errors++; $display("FAIL rnd%0d_tx_req: got %0d exp %0d", it, txreq_cnt - t0, hit ? n : 0); end
            end
            mstop();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy: got %b exp 0", it, busy); end
        end
    endtask

    task automatic test_reset_mid_read();
        bit ack;
        bit b;
        tx_data = 8'hE0;
        mstart();
        wbyte({ADDR, 1'b1}, ack);
        for (int i = 0; i < 3; i++) rbit(b);
        checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rmr_bit4_driven: got %b exp 0", sda); end
        rst = 1'b1;
        #(20);
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rmr_sda_release: got %b exp 1", sda); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmr_busy: got %b exp 0", busy); end
        checks++; if (addr_hit !== 1'b0) begin errors++; $display("FAIL rmr_addr_hit: got %b exp 0", addr_hit); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmr_rx_data: got %h exp 00", rx_data); end
        checks++; if (tx_req !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL rmr_pulses: got %b%b exp 00", tx_req, rx_valid); end
        #(30);
        rst = 1'b0;
        #(Q);
        mstart();
        wbyte({ADDR, 1'b0}, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rmr_reack: got %b exp 1", ack); end
        checks++; if (addr_hit !== 1'b1) begin errors++; $display("FAIL rmr_rehit: got %b exp 1", addr_hit); end
        mstop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmr_busy_stop: got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_addr_mismatch();
        test_read_two();
        test_repeated_start();
        test_write_burst(3, 1'b0);
        test_write_burst(5, 1'b1);
        test_random(12);
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(5ms);
        $display("FAIL timeout: simulation exceeded time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
